// File: rtl/bus_arb_pkg.sv
// Shared definitions for the round-robin system-bus arbiter.
//   arb_state_e            : arbiter FSM states
//   MODE_WRITE / MODE_READ : meaning of the master mode line
//   DEFAULT_TIMEOUT_CYCLES : default CONNECT watchdog limit (BUS_TIMEOUT_EN builds)
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADDR    = 2'd1,
        ACK     = 2'd2,
        CONNECT = 2'd3
    } arb_state_e;

    localparam logic MODE_WRITE = 1'b1;
    localparam logic MODE_READ  = 1'b0;

    localparam int DEFAULT_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/rr_select.sv
// Rotating priority selector used by the arbiter.
// Finds the first set bit of req_i searching upward from ptr_i, wrapping
// modulo NUM_MASTERS. Purely combinational.
//   req_i : request vector
//   ptr_i : index where the search starts
//   gnt_o : one-hot winner (all zero when nothing is requested)
//   idx_o : index of the winner (0 when nothing is requested)
module rr_select #(
    parameter int  NUM_MASTERS = 2,
    localparam int IDX_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic [IDX_W-1:0]       ptr_i,
    output logic [NUM_MASTERS-1:0] gnt_o,
    output logic [IDX_W-1:0]       idx_o
);

    logic found_s;
    int   cand_s;

    // Walk the request vector once, starting at the pointer, and keep the first hit.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        found_s = 1'b0;
        cand_s  = 0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            cand_s = (int'(ptr_i) + i) % NUM_MASTERS;
            if (!found_s && req_i[IDX_W'(cand_s)]) begin
                found_s                  = 1'b1;
                gnt_o[IDX_W'(cand_s)]    = 1'b1;
                idx_o                    = IDX_W'(cand_s);
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin system-bus arbiter with serial slave select.
// A granted master shifts SEL_W select bits (MSB first, one per valid cycle);
// the value picks one of NUM_SLAVES slave ports, and the handshake lines are
// then routed between the pair until the master drops its request.
// Optional macro BUS_TIMEOUT_EN adds a CONNECT watchdog of TIMEOUT_CYCLES
// silent slave cycles; without it CONNECT is held indefinitely.
// Ports:
//   clk, rst                          : clock, asynchronous active-high reset
//   m_req / m_grant                   : per-master request / registered one-hot grant
//   m_mode, m_wr_bus, m_master_valid,
//   m_master_ready                    : master-driven serial lines
//   m_rd_bus, m_slave_valid,
//   m_slave_ready                     : routed slave lines back to the master
//   m_ack / m_err                     : 1-cycle select-accepted / decode-error (or timeout) pulses
//   s_mode, s_wr_bus, s_master_valid,
//   s_master_ready                    : routed master lines to the slaves
//   s_rd_bus, s_slave_valid,
//   s_slave_ready                     : slave-driven lines
module bus_arbiter_rr
    import bus_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 4
`ifdef BUS_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] m_req,
    output logic [NUM_MASTERS-1:0] m_grant,
    input  logic [NUM_MASTERS-1:0] m_mode,
    input  logic [NUM_MASTERS-1:0] m_wr_bus,
    input  logic [NUM_MASTERS-1:0] m_master_valid,
    input  logic [NUM_MASTERS-1:0] m_master_ready,
    output logic [NUM_MASTERS-1:0] m_rd_bus,
    output logic [NUM_MASTERS-1:0] m_slave_valid,
    output logic [NUM_MASTERS-1:0] m_slave_ready,
    output logic [NUM_MASTERS-1:0] m_ack,
    output logic [NUM_MASTERS-1:0] m_err,
    output logic [NUM_SLAVES-1:0]  s_mode,
    output logic [NUM_SLAVES-1:0]  s_wr_bus,
    output logic [NUM_SLAVES-1:0]  s_master_valid,
    output logic [NUM_SLAVES-1:0]  s_master_ready,
    input  logic [NUM_SLAVES-1:0]  s_rd_bus,
    input  logic [NUM_SLAVES-1:0]  s_slave_valid,
    input  logic [NUM_SLAVES-1:0]  s_slave_ready
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int SEL_W = $clog2(NUM_SLAVES);
    localparam int CNT_W = $clog2(SEL_W + 1);

    arb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       g_q, g_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [NUM_MASTERS-1:0] ack_q, ack_d;
    logic [NUM_MASTERS-1:0] err_q, err_d;

    logic [NUM_MASTERS-1:0] req_eff_s;
    logic [NUM_MASTERS-1:0] rr_gnt_s;
    logic [IDX_W-1:0]       rr_idx_s;
    logic                   route_en_s;

    // Pointer just past the master that finished, wrapping to 0.
    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] cur);
        if (int'(cur) >= NUM_MASTERS - 1) begin
            return '0;
        end else begin
            return cur + IDX_W'(1);
        end
    endfunction

`ifdef BUS_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    // Masters that timed out stay blocked until they release their request.
    logic [NUM_MASTERS-1:0] blk_q, blk_d;
    logic                   activity_s;

    assign activity_s = s_slave_valid[sel_q] | s_slave_ready[sel_q];
    assign req_eff_s  = m_req & ~blk_q;
`else
    assign req_eff_s  = m_req;
`endif

    rr_select #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_rr_select (
        .req_i (req_eff_s),
        .ptr_i (ptr_q),
        .gnt_o (rr_gnt_s),
        .idx_o (rr_idx_s)
    );

    // Next-state and pulse logic for the arbitration FSM.
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        ack_d   = '0;
        err_d   = '0;
`ifdef BUS_TIMEOUT_EN
        to_cnt_d = '0;
        blk_d    = blk_q & m_req;
`endif
        case (state_q)
            IDLE: begin
                if (|req_eff_s) begin
                    g_d     = rr_idx_s;
                    grant_d = rr_gnt_s;
                    sel_d   = '0;
                    cnt_d   = '0;
                    state_d = ADDR;
                end else begin
                    grant_d = '0;
                end
            end
            ADDR: begin
                if (!m_req[g_q]) begin
                    grant_d = '0;
                    state_d = IDLE;
                end else if (m_master_valid[g_q]) begin
                    sel_d = (sel_q << 1) | SEL_W'(m_wr_bus[g_q]);
                    cnt_d = cnt_q + CNT_W'(1);
                    // The pulse is registered, so decide it on the last bit.
                    if (cnt_q == CNT_W'(SEL_W - 1)) begin
                        state_d = ACK;
                        if (int'(sel_d) < NUM_SLAVES) begin
                            ack_d[g_q] = 1'b1;
                        end else begin
                            err_d[g_q] = 1'b1;
                        end
                    end else begin
                        state_d = ADDR;
                    end
                end else begin
                    state_d = ADDR;
                end
            end
            ACK: begin
                if (int'(sel_q) < NUM_SLAVES) begin
                    state_d = CONNECT;
                end else begin
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            CONNECT: begin
                if (!m_req[g_q]) begin
                    grant_d = '0;
                    ptr_d   = next_ptr(g_q);
                    state_d = IDLE;
                end else begin
`ifdef BUS_TIMEOUT_EN
                    if (activity_s) begin
                        to_cnt_d = '0;
                    end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        err_d[g_q] = 1'b1;
                        blk_d[g_q] = 1'b1;
                        grant_d    = '0;
                        ptr_d      = next_ptr(g_q);
                        state_d    = IDLE;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
`else
                    state_d = CONNECT;
`endif
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            g_q      <= '0;
            ptr_q    <= '0;
            sel_q    <= '0;
            cnt_q    <= '0;
            grant_q  <= '0;
            ack_q    <= '0;
            err_q    <= '0;
`ifdef BUS_TIMEOUT_EN
            to_cnt_q <= '0;
            blk_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            ptr_q    <= ptr_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
`ifdef BUS_TIMEOUT_EN
            to_cnt_q <= to_cnt_d;
            blk_q    <= blk_d;
`endif
        end
    end

    assign m_grant = grant_q;
    assign m_ack   = ack_q;
    assign m_err   = err_q;

    // Routing is gated by the live request so a release cuts the path in the same cycle.
    assign route_en_s = (state_q == CONNECT) && m_req[g_q];

    // Crossbar between the granted master and the selected slave.
    always_comb begin
        s_mode         = '0;
        s_wr_bus       = '0;
        s_master_valid = '0;
        s_master_ready = '0;
        m_rd_bus       = '0;
        m_slave_valid  = '0;
        m_slave_ready  = '0;
        if (route_en_s) begin
            s_mode[sel_q]         = m_mode[g_q];
            s_wr_bus[sel_q]       = m_wr_bus[g_q];
            s_master_valid[sel_q] = m_master_valid[g_q];
            s_master_ready[sel_q] = m_master_ready[g_q];
            m_rd_bus[g_q]         = s_rd_bus[sel_q];
            m_slave_valid[g_q]    = s_slave_valid[sel_q];
            m_slave_ready[g_q]    = s_slave_ready[sel_q];
        end else begin
            s_mode = '0;
        end
    end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr with 3 masters and 3 slaves
// (non-power-of-two slave count, so select value 3 is a decode error).
module tb_bus_arbiter_rr;

    localparam int NM   = 3;
    localparam int NS   = 3;
    localparam int SELW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NM-1:0] m_req, m_mode, m_wr_bus, m_master_valid, m_master_ready;
    logic [NM-1:0] m_grant, m_rd_bus, m_slave_valid, m_slave_ready, m_ack, m_err;
    logic [NS-1:0] s_mode, s_wr_bus, s_master_valid, s_master_ready;
    logic [NS-1:0] s_rd_bus, s_slave_valid, s_slave_ready;

    int n_pass  = 0;
    int n_total = 0;

    // reference model: who owns the bus, how many select bits it sent, etc.
    int mo_owner, mo_nbits, mo_sel, mo_ptr;
    bit mo_linked;

    typedef struct {
        logic [NM-1:0] req;
        logic [NM-1:0] valid;
        logic [NM-1:0] wr;
        logic [NS-1:0] srd;
        logic [NM-1:0] e_grant;
        logic [NM-1:0] e_ack;
        logic [NM-1:0] e_err;
        logic [NS-1:0] e_swr;
        logic [NM-1:0] e_mrd;
    } vec_t;

    vec_t tbl[20];

    always #5 clk = ~clk;

    bus_arbiter_rr #(
        .NUM_MASTERS (NM),
        .NUM_SLAVES  (NS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .m_req          (m_req),
        .m_grant        (m_grant),
        .m_mode         (m_mode),
        .m_wr_bus       (m_wr_bus),
        .m_master_valid (m_master_valid),
        .m_master_ready (m_master_ready),
        .m_rd_bus       (m_rd_bus),
        .m_slave_valid  (m_slave_valid),
        .m_slave_ready  (m_slave_ready),
        .m_ack          (m_ack),
        .m_err          (m_err),
        .s_mode         (s_mode),
        .s_wr_bus       (s_wr_bus),
        .s_master_valid (s_master_valid),
        .s_master_ready (s_master_ready),
        .s_rd_bus       (s_rd_bus),
        .s_slave_valid  (s_slave_valid),
        .s_slave_ready  (s_slave_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic zero_inputs();
        m_req = '0; m_mode = '0; m_wr_bus = '0; m_master_valid = '0; m_master_ready = '0;
        s_rd_bus = '0; s_slave_valid = '0; s_slave_ready = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, m_grant, 0);
        chk({tag, "_ack"}, m_ack, 0);
        chk({tag, "_err"}, m_err, 0);
        chk({tag, "_mrd"}, m_rd_bus, 0);
        chk({tag, "_msv"}, m_slave_valid, 0);
        chk({tag, "_msr"}, m_slave_ready, 0);
        chk({tag, "_smode"}, s_mode, 0);
        chk({tag, "_swr"}, s_wr_bus, 0);
        chk({tag, "_smv"}, s_master_valid, 0);
        chk({tag, "_smr"}, s_master_ready, 0);
    endtask

    task automatic model_reset();
        mo_owner = -1; mo_nbits = 0; mo_sel = 0; mo_ptr = 0; mo_linked = 1'b0;
    endtask

    // Expected outputs for the current cycle from model state and live inputs.
    task automatic check_model();
        logic [NM-1:0] eg, ea, ee, erd, esv, esr;
        logic [NS-1:0] emo, ewr, emv, emr;
        eg = '0; ea = '0; ee = '0; erd = '0; esv = '0; esr = '0;
        emo = '0; ewr = '0; emv = '0; emr = '0;
        if (mo_owner >= 0) begin
            eg[mo_owner] = 1'b1;
            if (!mo_linked && mo_nbits == SELW) begin
                if (mo_sel < NS) ea[mo_owner] = 1'b1;
                else             ee[mo_owner] = 1'b1;
            end
            if (mo_linked && m_req[mo_owner]) begin
                emo[mo_sel] = m_mode[mo_owner];
                ewr[mo_sel] = m_wr_bus[mo_owner];
                emv[mo_sel] = m_master_valid[mo_owner];
                emr[mo_sel] = m_master_ready[mo_owner];
                erd[mo_owner] = s_rd_bus[mo_sel];
                esv[mo_owner] = s_slave_valid[mo_sel];
                esr[mo_owner] = s_slave_ready[mo_sel];
            end
        end
        chk("mdl_grant", m_grant, eg);
        chk("mdl_ack", m_ack, ea);
        chk("mdl_err", m_err, ee);
        chk("mdl_mrd", m_rd_bus, erd);
        chk("mdl_msv", m_slave_valid, esv);
        chk("mdl_msr", m_slave_ready, esr);
        chk("mdl_smode", s_mode, emo);
        chk("mdl_swr", s_wr_bus, ewr);
        chk("mdl_smv", s_master_valid, emv);
        chk("mdl_smr", s_master_ready, emr);
    endtask

    // Advance the model by one clock using the inputs the DUT is about to sample.
    task automatic model_step();
        if (mo_owner < 0) begin
            for (int k = 0; k < NM; k++) begin
                int c;
                c = (mo_ptr + k) % NM;
                if (mo_owner < 0 && m_req[c]) begin
                    mo_owner = c; mo_nbits = 0; mo_sel = 0;
                end
            end
        end else if (!mo_linked && mo_nbits < SELW) begin
            if (!m_req[mo_owner]) begin
                mo_owner = -1;
            end else if (m_master_valid[mo_owner]) begin
                mo_sel   = mo_sel * 2 + int'(m_wr_bus[mo_owner]);
                mo_nbits = mo_nbits + 1;
            end
        end else if (!mo_linked) begin
            if (mo_sel < NS) mo_linked = 1'b1;
            else             mo_owner  = -1;
        end else if (!m_req[mo_owner]) begin
            mo_ptr    = (mo_owner + 1) % NM;
            mo_owner  = -1;
            mo_linked = 1'b0;
        end
    endtask

    // Entered just after a negedge with inputs already set; returns at the next negedge.
    task automatic cyc();
        #1;
        check_model();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        zero_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        //            req     valid   wr      srd     grant   ack     err     swr     mrd
        tbl[0]  = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        tbl[1]  = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        tbl[2]  = '{3'b001, 3'b001, 3'b001, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
        tbl[3]  = '{3'b001, 3'b001, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
        tbl[4]  = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000};
        tbl[5]  = '{3'b001, 3'b001, 3'b001, 3'b100, 3'b001, 3'b000, 3'b000, 3'b100, 3'b001};
        tbl[6]  = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
        tbl[7]  = '{3'b000, 3'b001, 3'b001, 3'b100, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
        tbl[8]  = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        tbl[9]  = '{3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        tbl[10] = '{3'b010, 3'b010, 3'b010, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000};
        tbl[11] = '{3'b010, 3'b010, 3'b010, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000};
        tbl[12] = '{3'b010, 3'b000, 3'b010, 3'b000, 3'b010, 3'b000, 3'b010, 3'b000, 3'b000};
        tbl[13] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        tbl[14] = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        tbl[15] = '{3'b011, 3'b001, 3'b001, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
        tbl[16] = '{3'b010, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
        tbl[17] = '{3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        tbl[18] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000};
        tbl[19] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};

        // reset state
        zero_inputs();
        #3;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // table: select 2'b10, routing, release, decode error 2'b11, abort
        for (int r = 0; r < 20; r++) begin
            m_req          = tbl[r].req;
            m_master_valid = tbl[r].valid;
            m_wr_bus       = tbl[r].wr;
            s_rd_bus       = tbl[r].srd;
            #1;
            chk($sformatf("tbl%0d_grant", r), m_grant, tbl[r].e_grant);
            chk($sformatf("tbl%0d_ack", r), m_ack, tbl[r].e_ack);
            chk($sformatf("tbl%0d_err", r), m_err, tbl[r].e_err);
            chk($sformatf("tbl%0d_swr", r), s_wr_bus, tbl[r].e_swr);
            chk($sformatf("tbl%0d_mrd", r), m_rd_bus, tbl[r].e_mrd);
            @(posedge clk);
            @(negedge clk);
        end

        // simultaneous requests, release, immediate re-request
        do_reset();
        m_req = 3'b011; cyc();
        chk("rr_first_m0", m_grant, 3'b001);
        m_master_valid = 3'b001; m_wr_bus = 3'b001; cyc();
        m_wr_bus = 3'b000; cyc();
        chk("ack_m0", m_ack, 3'b001);
        m_master_valid = 3'b000; cyc();
        m_wr_bus = 3'b001; m_master_valid = 3'b001; s_rd_bus = 3'b100; cyc();
        chk("m0_swr_route", s_wr_bus, 3'b100);
        chk("m0_mrd_route", m_rd_bus, 3'b001);
        m_req = 3'b010; m_wr_bus = '0; m_master_valid = '0; s_rd_bus = '0; cyc();
        chk("release_grant_drop", m_grant, 3'b000);
        m_req = 3'b011; cyc();
        chk("m1_after_release", m_grant, 3'b010);
        m_master_valid = 3'b010; m_wr_bus = 3'b000; cyc();
        m_wr_bus = 3'b010; cyc();
        chk("ack_m1", m_ack, 3'b010);
        m_master_valid = '0; m_wr_bus = '0; cyc();
        m_mode = 3'b010; m_master_ready = 3'b010; s_slave_valid = 3'b010; cyc();
        chk("m1_mode_route", s_mode, 3'b010);
        chk("m1_sv_route", m_slave_valid, 3'b010);
        m_req = 3'b001; m_mode = '0; m_master_ready = '0; s_slave_valid = '0; cyc();
        cyc();
        chk("m0_rerequest_served", m_grant, 3'b001);
        m_req = '0; cyc(); cyc();

        // reset asserted in the middle of CONNECT
        do_reset();
        m_req = 3'b100; cyc();
        chk("m2_grant", m_grant, 3'b100);
        m_master_valid = 3'b100; m_wr_bus = 3'b100; cyc();
        m_wr_bus = 3'b000; cyc();
        m_master_valid = '0; cyc();
        m_mode = '1; m_wr_bus = '1; m_master_valid = '1; m_master_ready = '1;
        s_rd_bus = '1; s_slave_valid = '1; s_slave_ready = '1;
        #1;
        chk("pre_rst_route", s_wr_bus, 3'b100);
        #1;
        rst = 1'b1;
        #1;
        chk_all_zero("mid_rst");
        @(negedge clk);
        zero_inputs();
        model_reset();
        m_req = 3'b110;
        @(negedge clk);
        rst = 1'b0;
        cyc();
        chk("post_rst_lowest", m_grant, 3'b010);
        m_req = '0; cyc(); cyc();

        // randomized traffic against the reference model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NM; i++) begin
                if (m_req[i]) m_req[i] = ($urandom_range(0, 9) != 0);
                else          m_req[i] = ($urandom_range(0, 3) == 0);
            end
            m_mode         = NM'($urandom);
            m_wr_bus       = NM'($urandom);
            m_master_valid = NM'($urandom);
            m_master_ready = NM'($urandom);
            s_rd_bus       = NS'($urandom);
            s_slave_valid  = NS'($urandom);
            s_slave_ready  = NS'($urandom);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
- Parametrised successor to the single-master system-bus arbiter.
- Arbitrates NUM_MASTERS serial master ports using a round-robin policy.
- Captures a serial slave-select field from the granted master and decodes it to one of NUM_SLAVES slave ports (highest index = bus bridge by convention).
- Routes the serial handshake lines between that master and slave until the master releases its request.

Parameters:
- NUM_MASTERS, 2, number of master ports (>=1).
- NUM_SLAVES, 4, number of slave ports (>=2); SEL_W = $clog2(NUM_SLAVES) is a localparam.
- TIMEOUT_CYCLES, 64, watchdog limit, used only with BUS_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- m_req  in  NUM_MASTERS  bus request per master
- m_grant  out  NUM_MASTERS  one-hot grant
- m_mode  in  NUM_MASTERS  1=write, 0=read
- m_wr_bus  in  NUM_MASTERS  serial data from master
- m_master_valid  in  NUM_MASTERS  master serial bit valid
- m_master_ready  in  NUM_MASTERS  master ready for read data
- m_rd_bus  out  NUM_MASTERS  serial data to master
- m_slave_valid  out  NUM_MASTERS  routed slave valid
- m_slave_ready  out  NUM_MASTERS  routed slave ready
- m_ack  out  NUM_MASTERS  1-cycle select-accepted pulse
- m_err  out  NUM_MASTERS  1-cycle decode-error / timeout pulse
- s_mode, s_wr_bus, s_master_valid, s_master_ready  out  NUM_SLAVES each  routed master lines
- s_rd_bus, s_slave_valid, s_slave_ready  in  NUM_SLAVES each  slave lines

Behaviour:
- Reset:
  - All outputs 0; state IDLE; rr_ptr 0; sel 0; bit counter 0.
  - Reset takes effect immediately in any state.
- FSM states: IDLE, ADDR, ACK, CONNECT.
- IDLE:
  - When any m_req is set, latch g = first requester found searching upward from rr_ptr (mod NUM_MASTERS).
  - Set m_grant[g] registered; grant is visible 1 cycle after req is sampled. Go to ADDR.
- ADDR:
  - Each cycle with m_master_valid[g]=1, shift m_wr_bus[g] into sel, MSB first, and increment the counter.
  - After SEL_W accepted bits, go to ACK.
  - If m_req[g] drops, abort to IDLE (no ack, no err).
- ACK (1 cycle):
  - If sel < NUM_SLAVES: m_ack[g]=1, go to CONNECT.
  - Otherwise: m_err[g]=1, drop the grant, go to IDLE.
- CONNECT:
  - Combinational routing:
    - s_mode/s_wr_bus/s_master_valid/s_master_ready[sel] = the master[g] lines.
    - m_rd_bus/m_slave_valid/m_slave_ready[g] = the slave[sel] lines.
  - All non-selected outputs are held 0.
  - When m_req[g]=0 is sampled: routing stops that same cycle, the grant drops the next cycle, rr_ptr = (g+1) mod NUM_MASTERS, go to IDLE.
- Routing is active only in CONNECT; select bits are never forwarded to a slave.
- Simultaneous requests: round-robin order from rr_ptr. A master re-requesting immediately waits behind the other pending masters.
- Requests from non-granted masters are ignored until IDLE.
- NUM_MASTERS=1: rr_ptr stays 0.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- With the macro:
  - A counter runs in CONNECT and clears on any cycle where routed s_slave_valid or s_slave_ready is 1.
  - On reaching TIMEOUT_CYCLES: m_err[g] pulses 1 cycle, routing stops, grant drops, rr_ptr advances, go to IDLE.
  - The master must then deassert m_req before it is re-granted.
- Without the macro: no counter, and CONNECT is held indefinitely.

Decomposition:
- Package bus_arb_pkg:
  - arb_state_e enum (IDLE, ADDR, ACK, CONNECT).
  - MODE_WRITE/MODE_READ constants.
  - Default TIMEOUT_CYCLES constant.
- Sub-module rr_select:
  - Parametrised by NUM_MASTERS.
  - Inputs req and ptr; outputs one-hot gnt plus its index.
  - Purely combinational; instantiated once.

Test Plan:
- Single master 0, select bits 2'b10 (NUM_SLAVES=4):
  - m_grant[0] 1 cycle after req.
  - m_ack[0] pulses the cycle after the 2nd bit.
  - s_wr_bus[2] follows m_wr_bus[0]; s*_0/1/3 stay 0.
  - m_rd_bus[0] follows s_rd_bus[2].
- Masters 0 and 1 request together, ptr=0:
  - Master 0 is served first; after release, master 1 is granted within 2 cycles.
  - Master 0 re-requests at once and is served after master 1.
- NUM_SLAVES=3, select 2'b11:
  - m_err[0] pulses once, no m_ack, no s_* activity, grant drops, back to IDLE.
- Master drops req after 1 of 2 select bits:
  - Return to IDLE, no ack or err, another pending master granted next.
- rst asserted mid-CONNECT:
  - All s_* and m_* outputs are 0 in the same cycle; after release, the first request is granted to the lowest requester (rr_ptr=0).
- BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave silent in CONNECT:
  - m_err pulses on the 8th idle cycle and the grant drops.
  - A slave_valid toggle on cycle 5 restarts the count.
